spike_event_logger: RTL and testbench
=====================================

Name: spike_event_logger

Overview:
- Downstream consumer of the leaky integrate-and-fire neuron.
- Watches the neuron's spike output and membrane-state bus.
- On each new spike, records a {timestamp, membrane state} event into a small FIFO.
- Drains events over a valid/ready stream, so a readout stage can reconstruct spike timing without sampling every cycle.
- Tracks overflow with a sticky flag and a saturating drop counter.

Parameters:
- TS_W, 8, width of the free-running timestamp counter (wraps modulo 2^TS_W).
- STATE_W, 8, width of the sampled membrane state.
- DEPTH, 8, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  enable; gates timestamp increment and event capture.
- spike  in  1  neuron spike output.
- state  in  STATE_W  neuron membrane state, sampled with the spike.
- clr_ovf  in  1  one-cycle pulse; clears overflow and drop_count.
- evt_ready  in  1  consumer ready.
- evt_valid  out  1  FIFO non-empty.
- evt_data  out  TS_W+STATE_W  {timestamp, state} of FIFO head; zero when evt_valid=0.
- fifo_count  out  $clog2(DEPTH)+1  entries held, 0..DEPTH.
- overflow  out  1  sticky: at least one event dropped since last clear.
- drop_count  out  8  events dropped since last clear; saturates at 255.

Behaviour:
- Reset (rst=1 at a clock edge) applies regardless of other inputs:
  - timestamp=0, spike_q=0, FIFO emptied, fifo_count=0, evt_valid=0, evt_data=0, overflow=0, drop_count=0.
  - Reset mid-drain discards all queued events.
- Timestamp: ts increments by 1 each cycle en=1; holds when en=0; wraps from 2^TS_W-1 to 0 with no flag.
- Edge detect:
  - spike_q <= spike every cycle, independent of en.
  - push = en & spike & ~spike_q.
  - A spike held high for N cycles yields exactly one event.
  - A spike rising while en=0 is lost; it does not re-trigger when en rises if spike is still high.
- Captured entry = {ts, state}: both are values present in the push cycle, with ts taken before its increment.
- Write latency: entry visible at evt_data with evt_valid=1 on the cycle after the push edge.
- Read handshake:
  - pop = evt_valid & evt_ready.
  - The head advances on the clock edge.
  - evt_data and evt_valid stay stable while evt_valid=1 and evt_ready=0.
  - evt_ready while empty has no effect.
- Ordering: strict FIFO; read/write pointers wrap modulo DEPTH.
- fifo_count:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on push&pop, or on neither.
- Full (count=DEPTH):
  - push with pop in the same cycle: accepted, count stays DEPTH, no drop.
  - push without pop: entry discarded; overflow <= 1; drop_count += 1 (saturate at 255); FIFO contents unchanged.
- Empty (count=0): push only, count becomes 1. Push and pop cannot coincide, since evt_valid=0.
- clr_ovf:
  - Clears overflow and drop_count the next edge.
  - If a drop occurs the same cycle, the drop wins: overflow=1, drop_count=1.
- No combinational path from spike or state to any output; evt_data depends only on registered state.

Test Plan:
- Single spike at ts=5 with state=0x7A, evt_ready=1 -> evt_valid high one cycle later; evt_data=0x057A; count returns to 0 after pop.
- spike held high 10 cycles, then low 3, then high 1 -> exactly two events, timestamps 3 cycles apart after the first falling edge plus gap; no duplicates.
- evt_ready=0, 9 distinct spikes -> count=8, overflow=1, drop_count=1; draining returns the first 8 in order; the 9th is absent.
- FIFO full, evt_ready=1 and new spike on the same cycle -> count stays 8, overflow stays 0; the new event is last out.
- en=1 for 256+ cycles, spikes at ts=254 and ts=1 (post-wrap) -> evt_data timestamps 0xFE then 0x01, in order.
- 4 queued events, overflow set, then rst=1 for one cycle -> next cycle evt_valid=0, evt_data=0, count=0, overflow=0, drop_count=0, ts restarts at 0.
- Drop and clr_ovf pulse in the same cycle -> overflow=1, drop_count=1.

Source files
------------

// File: rtl/spike_event_logger.sv
// Spike event logger: edge-detects neuron spikes, queues {timestamp, state}
// records in a small FIFO and drains them over a valid/ready stream.
module spike_event_logger #(
   parameter int TS_W    = 8,
   parameter int STATE_W = 8,
   parameter int DEPTH   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       spike,
   input  logic [STATE_W-1:0]         state,
   input  logic                       clr_ovf,
   input  logic                       evt_ready,
   output logic                       evt_valid,
   output logic [TS_W+STATE_W-1:0]    evt_data,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       overflow,
   output logic [7:0]                 drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = TS_W + STATE_W;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [TS_W-1:0] ts_q, ts_d;
   logic            spike_q, spike_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d;
   logic [7:0]      drop_q, drop_d;
   logic [DW-1:0]   mem_q [DEPTH];

   logic push, pop, full, accept, drop;

   assign evt_valid  = (count_q != '0);
   assign evt_data   = evt_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch can be inferred.
      ts_d       = ts_q;
      spike_d    = spike;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;

      push   = en & spike & ~spike_q;
      pop    = evt_valid & evt_ready;
      full   = (count_q == FULL_CNT);
      // A pop on a full FIFO frees the head slot in time for the same-cycle write.
      accept = push & (~full | pop);
      drop   = push & full & ~pop;

      if (en) ts_d = ts_q + TS_W'(1);
      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (accept && !pop) count_d = count_q + CW'(1);
      else if (pop && !accept) count_d = count_q - CW'(1);

      if (clr_ovf) begin
         overflow_d = 1'b0;
         drop_d     = '0;
      end
      if (drop) begin
         overflow_d = 1'b1;
         drop_d     = clr_ovf ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         ts_q       <= '0;
         spike_q    <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         ts_q       <= ts_d;
         spike_q    <= spike_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   // NOTE: the storage array is not reset; stale entries are never visible because evt_data is masked by evt_valid.
   always_ff @(posedge clk) begin
      if (accept && !rst) mem_q[wr_ptr_q] <= {ts_q, state};
   end

endmodule

// File: tb/tb_spike_event_logger.sv
// Self-checking bench for spike_event_logger: table vectors, directed corner
// sequences and randomized traffic checked against a queue-based model.
module tb_spike_event_logger;

   localparam int TS_W = 8, STATE_W = 8, DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst, en, spike, clr_ovf, evt_ready;
   logic [7:0]  state;
   logic        evt_valid, overflow;
   logic [15:0] evt_data;
   logic [3:0]  fifo_count;
   logic [7:0]  drop_count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int          m_ts;
   bit          m_prev;
   logic [15:0] m_q[$];
   bit          m_ovf;
   int          m_drop;

   spike_event_logger #(.TS_W(TS_W), .STATE_W(STATE_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .en(en), .spike(spike), .state(state),
      .clr_ovf(clr_ovf), .evt_ready(evt_ready), .evt_valid(evt_valid),
      .evt_data(evt_data), .fifo_count(fifo_count), .overflow(overflow),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst, en, spike, clr, ready;
      logic [7:0]  st;
      bit          e_valid;
      logic [15:0] e_data;
      int          e_count;
      bit          e_ovf;
      int          e_drop;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model by the spec's rules, clock the DUT.
   task automatic drive(input bit r, input bit e, input bit s, input logic [7:0] st,
                        input bit c, input bit rd);
      bit do_push, do_pop;
      rst = r; en = e; spike = s; state = st; clr_ovf = c; evt_ready = rd;
      if (r) begin
         m_ts = 0; m_prev = 0; m_q.delete(); m_ovf = 0; m_drop = 0;
      end else begin
         do_push = e && s && !m_prev;
         do_pop  = (m_q.size() != 0) && rd;
         if (do_pop) void'(m_q.pop_front());
         if (c) begin m_ovf = 0; m_drop = 0; end
         if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back({8'(m_ts), st});
            else begin
               m_ovf = 1;
               if (m_drop < 255) m_drop++;
            end
         end
         if (e) m_ts = (m_ts + 1) % 256;
         m_prev = s;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [15:0] exp_data;
      exp_data = (m_q.size() != 0) ? m_q[0] : 16'h0;
      check({tag, ".valid"}, 32'(evt_valid), 32'(m_q.size() != 0));
      check({tag, ".data"}, 32'(evt_data), 32'(exp_data));
      check({tag, ".count"}, 32'(fifo_count), 32'(m_q.size()));
      check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      check({tag, ".drop"}, 32'(drop_count), 32'(m_drop));
   endtask

   task automatic push_n(input int n, input bit rd);
      for (int i = 0; i < n; i++) begin
         drive(0, 1, 1, 8'(8'h10 + i), 0, rd);
         drive(0, 1, 0, 8'h00, 0, rd);
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < DEPTH + 1 && m_q.size() != 0; i++) begin
         check_model(tag);
         drive(0, 0, 0, 8'h00, 0, 1);
      end
      check_model(tag);
   endtask

   initial begin
      vec_t vecs[$];
      logic [15:0] first_out;

      rst = 1; en = 0; spike = 0; state = 0; clr_ovf = 0; evt_ready = 0;
      m_ts = 0; m_prev = 0; m_ovf = 0; m_drop = 0;

      // Single spike at ts=5, state 0x7A, consumer ready
      vecs.push_back('{1,0,0,0,0, 8'h00, 0, 16'h0000, 0, 0, 0});
      for (int i = 0; i < 5; i++)
         vecs.push_back('{0,1,0,0,0, 8'h00, 0, 16'h0000, 0, 0, 0});
      vecs.push_back('{0,1,1,0,1, 8'h7A, 1, 16'h057A, 1, 0, 0});
      vecs.push_back('{0,1,1,0,1, 8'h33, 0, 16'h0000, 0, 0, 0});
      vecs.push_back('{0,1,0,0,0, 8'h00, 0, 16'h0000, 0, 0, 0});
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].spike, vecs[i].st, vecs[i].clr, vecs[i].ready);
         check($sformatf("vec%0d.valid", i), 32'(evt_valid), 32'(vecs[i].e_valid));
         check($sformatf("vec%0d.data", i), 32'(evt_data), 32'(vecs[i].e_data));
         check($sformatf("vec%0d.count", i), 32'(fifo_count), 32'(vecs[i].e_count));
         check($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
         check($sformatf("vec%0d.drop", i), 32'(drop_count), 32'(vecs[i].e_drop));
      end

      // Held spike: 10 high, 3 low, 1 high -> two events, ts 0 and 13
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) drive(0, 1, 1, 8'hA1, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 8'h00, 0, 0);
      drive(0, 1, 1, 8'hB2, 0, 0);
      drive(0, 1, 0, 8'h00, 0, 0);
      check("held.count", 32'(fifo_count), 32'd2);
      check("held.first", 32'(evt_data), 32'h00A1);
      drive(0, 1, 0, 8'h00, 0, 1);
      check("held.second", 32'(evt_data), 32'h0DB2);
      drive(0, 1, 0, 8'h00, 0, 1);
      check("held.empty", 32'(evt_valid), 32'd0);

      // Rising edge while disabled is lost and does not re-trigger on enable
      drive(0, 0, 1, 8'h55, 0, 0);
      drive(0, 1, 1, 8'h55, 0, 0);
      check("en_gate.count", 32'(fifo_count), 32'd0);

      // Nine spikes, consumer stalled -> 8 kept, one dropped
      drive(1, 0, 0, 0, 0, 0);
      push_n(9, 0);
      check("ovf9.count", 32'(fifo_count), 32'd8);
      check("ovf9.ovf", 32'(overflow), 32'd1);
      check("ovf9.drop", 32'(drop_count), 32'd1);
      check_model("ovf9");
      drive(0, 0, 0, 8'h00, 0, 0);
      check("ovf9.stall_data", 32'(evt_data), 32'(m_q[0]));
      drain("ovf9.drain");

      // Full FIFO, simultaneous pop and push -> accepted, no drop, new event last
      drive(1, 0, 0, 0, 0, 0);
      push_n(8, 0);
      drive(0, 1, 1, 8'hEE, 0, 1);
      check("fullpp.count", 32'(fifo_count), 32'd8);
      check("fullpp.ovf", 32'(overflow), 32'd0);
      check("fullpp.last", 32'(m_q[7][7:0]), 32'h00EE);
      drive(0, 1, 0, 8'h00, 0, 0);
      drain("fullpp.drain");

      // Timestamp wrap: events at ts=254 and ts=1
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 254; i++) drive(0, 1, 0, 8'h00, 0, 0);
      drive(0, 1, 1, 8'hC1, 0, 0);
      drive(0, 1, 0, 8'h00, 0, 0);
      drive(0, 1, 0, 8'h00, 0, 0);
      drive(0, 1, 1, 8'hC2, 0, 0);
      check("wrap.first", 32'(evt_data), 32'hFEC1);
      drive(0, 1, 0, 8'h00, 0, 1);
      check("wrap.second", 32'(evt_data), 32'h01C2);

      // Reset with 4 queued and overflow set
      drive(1, 0, 0, 0, 0, 0);
      push_n(9, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 8'h00, 0, 1);
      check("prerst.count", 32'(fifo_count), 32'd4);
      check("prerst.ovf", 32'(overflow), 32'd1);
      drive(1, 1, 1, 8'h99, 0, 1);
      check("rst.valid", 32'(evt_valid), 32'd0);
      check("rst.data", 32'(evt_data), 32'd0);
      check("rst.count", 32'(fifo_count), 32'd0);
      check("rst.ovf", 32'(overflow), 32'd0);
      check("rst.drop", 32'(drop_count), 32'd0);
      drive(0, 1, 0, 8'h00, 0, 0);
      drive(0, 1, 1, 8'h44, 0, 0);
      check("rst.ts_restart", 32'(evt_data), 32'h0144);

      // Drop coinciding with clr_ovf -> drop wins
      drive(1, 0, 0, 0, 0, 0);
      push_n(11, 0);
      check("clr.pre_drop", 32'(drop_count), 32'd3);
      drive(0, 1, 1, 8'h77, 1, 0);
      check("clr.drop_ovf", 32'(overflow), 32'd1);
      check("clr.drop_cnt", 32'(drop_count), 32'd1);
      drive(0, 1, 0, 8'h00, 1, 0);
      check("clr.only_ovf", 32'(overflow), 32'd0);
      check("clr.only_cnt", 32'(drop_count), 32'd0);

      // Drop counter saturation at 255
      push_n(260, 0);
      check("sat.drop", 32'(drop_count), 32'd255);
      check_model("sat");

      // Randomized traffic against the model
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8, 1'($urandom),
               8'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4);
         check_model("rand");
      end

      first_out = 16'h0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
